// File: rtl/serial_link_arbiter.sv
// ---------------------------------------------------------------------------
// serial_link_arbiter
//
// Shares one serial transmit line between NREQ parallel-word requesters.
// A round-robin arbiter picks a winner while idle, latches its word, and the
// block then emits a frame: two '1' start bits, DATA_W payload bits MSB
// first, then GAP_CYC forced zero cycles.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   en          arbitration enable (only gates new grants)
//   req_valid   per-requester word available
//   req_data    requester i's word in bits [i*DATA_W +: DATA_W]
//   req_ready   one-hot accept, combinational, only in the accept cycle
//   ser_out     registered serial line, idles at 0
//   busy        high while a frame is in progress
//   grant_id    index of the current or last granted requester
//   frame_done  one-cycle pulse on the first idle cycle after a frame
// ---------------------------------------------------------------------------
module serial_link_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 32,
    parameter int GAP_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     ser_out,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     frame_done
);

    localparam int ID_W    = $clog2(NREQ);
    localparam int CNT_MAX = (DATA_W > GAP_CYC) ? ((DATA_W > 2) ? DATA_W : 2)
                                                : ((GAP_CYC > 2) ? GAP_CYC : 2);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                ser_q, ser_d;
    logic                done_q, done_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;

    logic [ID_W-1:0]     cand;
    logic [ID_W-1:0]     win_idx;
    logic                win_found;
    logic                accept;

    // Round-robin search starting one past the last winner. The reset term
    // keeps req_ready low while reset is held, even though state reads IDLE.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
        accept = rst_n && (state_q == IDLE) && en && win_found;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (win_idx == ID_W'(i));
        end
    end

    // Frame sequencer. ser_d is the value the line shows during the next
    // state, so the first start bit is loaded at the accept edge and each
    // payload bit is taken from the shift register MSB as it is shifted out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        shift_d = shift_q;
        ser_d   = 1'b0;
        done_d  = 1'b0;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = START;
                    shift_d = req_data[int'(win_idx)*DATA_W +: DATA_W];
                    grant_d = win_idx;
                    ptr_d   = win_idx;
                    ser_d   = 1'b1;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    ser_d   = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
                end else begin
                    ser_d = 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d = '0;
                    if (GAP_CYC == 0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    ser_d   = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset drops any frame in flight immediately; the pointer restarts at
    // NREQ-1 so requester 0 is the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
            grant_q <= '0;
            ptr_q   <= ID_W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ser_out    = ser_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;
    assign frame_done = done_q;

endmodule

// File: doc/serial_link_arbiter.md
Name: serial_link_arbiter

Overview:
- Shares one single-bit serial transmit line between NREQ parallel-word requesters.
- Arbitrates round-robin, latches the winner's word, and emits a frame: two start bits '1','1', then DATA_W payload bits MSB first, then GAP_CYC idle zeros.
- Sits on the transmit side of the serial self-test link and drives the downstream deserializer's data input.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 32, payload bits per frame.
- GAP_CYC, 2, forced zero cycles after the payload (0 allowed).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  arbitration enable; gates new grants only.
- req_valid  input  NREQ  per-requester word available.
- req_data  input  NREQ*DATA_W  requester i's word in bits [i*DATA_W +: DATA_W].
- req_ready  output  NREQ  one-hot accept; transfer when req_valid[i] && req_ready[i] at a clock edge.
- ser_out  output  1  registered serial line, idle 0.
- busy  output  1  high whenever a frame is in progress (state != IDLE).
- grant_id  output  clog2(NREQ)  index of the current or last granted requester.
- frame_done  output  1  one-cycle pulse on the first IDLE cycle after a frame.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, ser_out 0, busy 0, grant_id 0, frame_done 0, shift register 0, counter 0, round-robin pointer NREQ-1 (requester 0 wins first).
- States and transitions:
  - IDLE -> START on accept.
  - START (2 cycles) -> DATA.
  - DATA (DATA_W cycles) -> GAP, or -> IDLE if GAP_CYC = 0.
  - GAP (GAP_CYC cycles) -> IDLE.
- Accept:
  - Only in IDLE with en = 1 and at least one req_valid bit set.
  - Winner is the first valid index searching from pointer+1, wrapping modulo NREQ.
  - req_ready is combinational: only the winner's bit is high, and only in that cycle. All bits are 0 in any other state or when en = 0.
  - At the accept edge: latch the winner's word, set grant_id and pointer to the winner, load ser_out = 1.
- Serial timing, from the accept edge E0:
  - ser_out = 1 for 2 cycles.
  - Then payload bit DATA_W-1 down to bit 0, one per cycle.
  - Then 0 for GAP_CYC cycles.
  - Total frame length is 2 + DATA_W + GAP_CYC cycles; busy is high for exactly that span.
- Inter-frame spacing: at least GAP_CYC + 1 zero cycles separate two frames, because the IDLE accept cycle always outputs 0.
- Latched data is immune to later req_data or req_valid changes. A requester dropping req_valid mid-frame has no effect.
- en is sampled only in IDLE. Deasserting en mid-frame lets the frame complete; then the block stays IDLE until en returns.
- A requester that drops valid before it is granted is skipped without penalty. The pointer changes only on accept.
- Simultaneous requests are resolved purely by the pointer; there is no fixed priority after the first grant.
- frame_done:
  - Registered.
  - Asserted for exactly one cycle, coincident with the first IDLE cycle after the frame's last cycle.
  - A new accept may occur in that same cycle.
- Counter width is clog2(max(DATA_W, GAP_CYC, 2)) + 1. It is cleared on every state entry.
- Reset mid-frame aborts the frame. ser_out goes to 0 immediately, and no frame_done is generated.

Test Plan:
1. NREQ=4, DATA_W=32, GAP_CYC=2. req_valid=4'b0001, req_data[31:0]=0xA5A50001, en=1.
   - req_ready=4'b0001 for one cycle.
   - ser_out sequence: 1,1, then 1010_0101_1010_0101_0000_0000_0000_0001, then 0,0.
   - busy high for 36 cycles; frame_done pulses on cycle 37; grant_id=0.
2. req_valid=4'b1111 held, distinct words 0x11111111 to 0x44444444.
   - Grant order 0,1,2,3,0.
   - Exactly 3 zero cycles between frames.
   - Each frame carries its own word.
3. en=0 with req_valid=4'b0100: no req_ready, ser_out stays 0.
   - Raise en: grant_id=2.
   - Drop en at payload bit 10: frame finishes intact, and no second grant follows while en=0.
4. Assert rst_n=0 at payload bit 5 of a frame.
   - ser_out, busy, req_ready and frame_done go to 0 asynchronously.
   - After release, with valid=4'b1010, requester 1 wins first (pointer reset).
5. GAP_CYC=0, DATA_W=8, word 0x81.
   - ser_out: 1,1,1,0,0,0,0,0,0,1, then 0.
   - busy high for 10 cycles; a back-to-back request yields exactly 1 zero cycle between frames.
6. Mid-frame, change req_data[0] to 0xFFFFFFFF and drop req_valid[0].
   - The transmitted payload remains the latched value.
   - req_ready stays 0 throughout the frame.
